// File: rtl/cnt_m_ctl.sv
// cnt_m_ctl: modulo counter with run-control state machine.
//
// Counts from a start value toward a terminal value under a run-time
// modulus. It supports up/down counting, wrap or one-shot operation,
// synchronous load and clear, and a registered terminal pulse.
//
// Parameters:
//   width - counter and modulus bit width (>= 2)
//   model - default modulus used when mod_val == 0 (1 .. 2**width)
//
// Ports:
//   sys_clk    in   clock, all logic on the rising edge
//   sys_rst_n  in   synchronous active-low reset
//   start      in   arm/restart: cnt <= start value, enter RUN
//   clear      in   cnt <= 0, enter IDLE
//   en         in   count enable (RUN only)
//   dir        in   0 = up, 1 = down
//   one_shot   in   0 = wrap at terminal, 1 = stop in DONE
//   load       in   cnt <= load_val, saturated to M-1
//   load_val   in   value for load
//   mod_val    in   run-time modulus, 0 selects model
//   cnt        out  current count (registered)
//   ovf        out  one-cycle pulse after a terminal step
//   busy       out  state == RUN (registered)
//   done       out  state == DONE (registered)
module cnt_m_ctl #(
  parameter int width = 8,
  parameter int model = 16
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             start,
  input  logic             clear,
  input  logic             en,
  input  logic             dir,
  input  logic             one_shot,
  input  logic             load,
  input  logic [width-1:0] load_val,
  input  logic [width-1:0] mod_val,
  output logic [width-1:0] cnt,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  generate
    if (width < 2) begin : g_bad_width
      $error("cnt_m_ctl: width must be at least 2");
    end
    if (model < 1 || model > (2 ** width)) begin : g_bad_model
      $error("cnt_m_ctl: model must lie in 1 .. 2**width");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // The modulus can equal 2**width, so it is carried one bit wider.
  localparam logic [width:0]   MODEL_W = (width + 1)'(model);
  localparam logic [width-1:0] ONE     = width'(1);

  state_t             state_q, state_d;
  logic [width-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic               busy_q, done_q;

  logic [width:0]     mod_eff;
  logic [width-1:0]   mod_m1;
  logic [width-1:0]   start_v;
  logic [width-1:0]   term_v;
  logic [width-1:0]   load_sat;
  logic               cnt_oor;

  assign mod_eff  = (mod_val == '0) ? MODEL_W : {1'b0, mod_val};
  // M-1 in width bits: for M == 2**width the low bits are zero and the
  // subtraction wraps to all ones, which is the correct M-1.
  assign mod_m1   = mod_eff[width-1:0] - ONE;
  assign start_v  = dir ? mod_m1 : '0;
  assign term_v   = dir ? '0 : mod_m1;
  assign load_sat = ({1'b0, load_val} >= mod_eff) ? mod_m1 : load_val;
  // Only reachable after mod_val shrinks below the current count.
  assign cnt_oor  = ({1'b0, cnt_q} >= mod_eff);

  always_comb begin
    cnt_d   = cnt_q;
    state_d = state_q;
    ovf_d   = 1'b0;
    if (clear) begin
      cnt_d   = '0;
      state_d = IDLE;
    end else if (start) begin
      cnt_d   = start_v;
      state_d = RUN;
    end else if (load) begin
      cnt_d   = load_sat;
    end else if (state_q == RUN && en) begin
      if (cnt_q == term_v) begin
        ovf_d = 1'b1;
        if (one_shot) begin
          state_d = DONE;
        end else begin
          cnt_d = start_v;
        end
      end else if (cnt_oor) begin
        cnt_d = start_v;
      end else if (dir) begin
        cnt_d = cnt_q - ONE;
      end else begin
        cnt_d = cnt_q + ONE;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      busy_q  <= (state_d == RUN);
      done_q  <= (state_d == DONE);
    end
  end

  assign cnt  = cnt_q;
  assign ovf  = ovf_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
